adc_conv_scheduler: RTL and testbench

ADC_CONV_SCHEDULER -- requirements
Module: adc_conv_scheduler

---
 rtl/adc_conv_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_adc_conv_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_scheduler.sv
// ADC conversion scheduler: periodic/single-shot trigger, start strobe, result capture, show-ahead result FIFO.
// Optional WAIT-state watchdog is compiled in when ADC_SCHED_TIMEOUT_EN is defined.
module adc_conv_scheduler #(
   parameter int FIFO_DEPTH     = 4,
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk_dig_in,
   input  logic        rst,
   input  logic        enable_in,
   input  logic [15:0] period_in,
   input  logic        single_shot_in,
   output logic        start_conversion_out,
   input  logic        conversion_finished_in,
   input  logic [15:0] result_in,
   output logic [15:0] data_out,
   output logic        data_valid_out,
   input  logic        data_ready_in,
   output logic [4:0]  fifo_level_out,
   output logic        busy_out,
   output logic        missed_out,
   output logic        overflow_out,
   output logic        timeout_out,
   input  logic        clear_flags_in
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_START   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   logic [1:0]  state_reg, state_next;
   logic [3:0]  start_cnt_reg, start_cnt_next;
   logic [15:0] timer_reg, timer_next;
   logic        timer_pulse, trigger;
   logic        fin_d_reg, fin_edge;
   logic [15:0] capture_reg, capture_next;
   logic        push, push_ok, pop;
   logic        missed_reg, overflow_reg;
   logic        missed_set, overflow_set;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
   logic [4:0]    count_reg, count_next;
   logic [15:0]   head_reg, head_next;

   // Timer wraps at period_in-1; a period shrunk below the running count also wraps.
   always_comb begin
      timer_pulse = 1'b0;
      timer_next  = 16'd0;
      if (enable_in && (period_in != 16'd0)) begin
         if (timer_reg >= (period_in - 16'd1)) begin
            timer_pulse = 1'b1;
         end else begin
            timer_next = timer_reg + 16'd1;
         end
      end
   end

   assign trigger    = timer_pulse | single_shot_in;
   assign fin_edge   = conversion_finished_in & ~fin_d_reg;
   assign missed_set = trigger & (state_reg != ST_IDLE);

`ifdef ADC_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
   logic          timeout_reg, timeout_set;
`endif

   always_comb begin
      state_next     = state_reg;
      start_cnt_next = start_cnt_reg;
      capture_next   = capture_reg;
      push           = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      wait_cnt_next  = wait_cnt_reg;
      timeout_set    = 1'b0;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (trigger) begin
               state_next     = ST_START;
               start_cnt_next = 4'd0;
            end
         end
         ST_START: begin
            if (start_cnt_reg == 4'(START_CYCLES - 1)) begin
               state_next = ST_WAIT;
`ifdef ADC_SCHED_TIMEOUT_EN
               wait_cnt_next = '0;
`endif
            end else begin
               start_cnt_next = start_cnt_reg + 4'd1;
            end
         end
         ST_WAIT: begin
            if (fin_edge) begin
               capture_next = result_in;
               state_next   = ST_CAPTURE;
            end
`ifdef ADC_SCHED_TIMEOUT_EN
            else if (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
               state_next  = ST_IDLE;
               timeout_set = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
`endif
         end
         default: begin
            push       = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   // A full FIFO still accepts the push when the consumer frees a slot in the same cycle.
   assign pop          = (count_reg != 5'd0) & data_ready_in;
   assign push_ok      = push & ((count_reg != 5'(FIFO_DEPTH)) | pop);
   assign overflow_set = push & ~push_ok;
   assign rd_ptr_inc   = rd_ptr_reg + AW'(1);

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop})
         2'b10:   count_next = count_reg + 5'd1;
         2'b01:   count_next = count_reg - 5'd1;
         default: count_next = count_reg;
      endcase
   end

   // Registered head; bypass the write data when the new entry becomes the head.
   always_comb begin
      head_next = head_reg;
      if (pop) begin
         head_next = (push_ok && (count_reg == 5'd1)) ? capture_reg : mem[rd_ptr_inc];
      end else if (push_ok && (count_reg == 5'd0)) begin
         head_next = capture_reg;
      end
   end

   always_ff @(posedge clk_dig_in) begin
      if (!rst && push_ok) begin
         mem[wr_ptr_reg] <= capture_reg;
      end
   end

   always_ff @(posedge clk_dig_in) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         start_cnt_reg <= 4'd0;
         timer_reg     <= 16'd0;
         fin_d_reg     <= 1'b0;
         capture_reg   <= 16'd0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= 5'd0;
         head_reg      <= 16'd0;
         missed_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         start_cnt_reg <= start_cnt_next;
         timer_reg     <= timer_next;
         fin_d_reg     <= conversion_finished_in;
         capture_reg   <= capture_next;
         count_reg     <= count_next;
         head_reg      <= head_next;
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_inc;
         if (missed_set)          missed_reg <= 1'b1;
         else if (clear_flags_in) missed_reg <= 1'b0;
         if (overflow_set)        overflow_reg <= 1'b1;
         else if (clear_flags_in) overflow_reg <= 1'b0;
      end
   end

`ifdef ADC_SCHED_TIMEOUT_EN
   always_ff @(posedge clk_dig_in) begin
      if (rst) begin
         wait_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         if (timeout_set)         timeout_reg <= 1'b1;
         else if (clear_flags_in) timeout_reg <= 1'b0;
      end
   end
   assign timeout_out = timeout_reg;
`else
   // No watchdog in this build: the flag is constant low.
   assign timeout_out = (TIMEOUT_CYCLES < 0);
`endif

   assign start_conversion_out = (state_reg == ST_START);
   assign busy_out             = (state_reg != ST_IDLE);
   assign data_out             = head_reg;
   assign data_valid_out       = (count_reg != 5'd0);
   assign fifo_level_out       = count_reg;
   assign missed_out           = missed_reg;
   assign overflow_out         = overflow_reg;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed self-checking bench for adc_conv_scheduler (FIFO_DEPTH=4, START_CYCLES=2, TIMEOUT_CYCLES=64).
module tb_adc_conv_scheduler;

   logic        clk_dig_in = 1'b0;
   logic        rst = 1'b1;
   logic        enable_in = 1'b0;
   logic [15:0] period_in = 16'd0;
   logic        single_shot_in = 1'b0;
   logic        start_conversion_out;
   logic        conversion_finished_in = 1'b0;
   logic [15:0] result_in = 16'd0;
   logic [15:0] data_out;
   logic        data_valid_out;
   logic        data_ready_in = 1'b0;
   logic [4:0]  fifo_level_out;
   logic        busy_out;
   logic        missed_out;
   logic        overflow_out;
   logic        timeout_out;
   logic        clear_flags_in = 1'b0;

   int total = 0;
   int passed = 0;
   int failed = 0;
   int cyc = 0;

   always #5 clk_dig_in = ~clk_dig_in;
   always @(posedge clk_dig_in) cyc <= cyc + 1;

   adc_conv_scheduler #(
      .FIFO_DEPTH(4),
      .START_CYCLES(2),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk_dig_in(clk_dig_in),
      .rst(rst),
      .enable_in(enable_in),
      .period_in(period_in),
      .single_shot_in(single_shot_in),
      .start_conversion_out(start_conversion_out),
      .conversion_finished_in(conversion_finished_in),
      .result_in(result_in),
      .data_out(data_out),
      .data_valid_out(data_valid_out),
      .data_ready_in(data_ready_in),
      .fifo_level_out(fifo_level_out),
      .busy_out(busy_out),
      .missed_out(missed_out),
      .overflow_out(overflow_out),
      .timeout_out(timeout_out),
      .clear_flags_in(clear_flags_in)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_dig_in);
      #1;
   endtask

   // Full conversion from IDLE; optionally pops in the CAPTURE cycle.
   task automatic do_conv(input logic [15:0] r, input logic pop_cap);
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      step(2);
      conversion_finished_in = 1'b1;
      result_in = r;
      step(1);
      conversion_finished_in = 1'b0;
      data_ready_in = pop_cap;
      step(1);
      data_ready_in = 1'b0;
   endtask

   task automatic wait_start(input string tag, output int t);
      int i;
      i = 0;
      while (!start_conversion_out && i < 150) begin
         step(1);
         i++;
      end
      check(tag, start_conversion_out, 1);
      t = cyc;
   endtask

   initial begin
      int t1, t2;
      logic [15:0] exp_q [4];
      exp_q = '{16'd101, 16'd102, 16'd103, 16'd200};

      // Reset, with a trigger pulse that must be ignored
      single_shot_in = 1'b1;
      step(2);
      single_shot_in = 1'b0;
      step(1);
      rst = 1'b0;
      step(1);
      check("rst_start", start_conversion_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_valid", data_valid_out, 0);
      check("rst_level", fifo_level_out, 0);
      check("rst_data", data_out, 0);
      check("rst_flags", {missed_out, overflow_out, timeout_out}, 0);

      // Basic single-shot conversion with exact strobe timing
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      check("ss_start_c1", start_conversion_out, 1);
      check("ss_busy", busy_out, 1);
      step(1);
      check("ss_start_c2", start_conversion_out, 1);
      step(1);
      check("ss_start_c3", start_conversion_out, 0);
      check("ss_busy_wait", busy_out, 1);
      conversion_finished_in = 1'b1;
      result_in = 16'hA5A5;
      step(1);
      conversion_finished_in = 1'b0;
      check("ss_capture_valid", data_valid_out, 0);
      step(1);
      check("ss_level", fifo_level_out, 1);
      check("ss_valid", data_valid_out, 1);
      check("ss_data", data_out, 16'hA5A5);
      check("ss_idle", busy_out, 0);
      data_ready_in = 1'b1;
      step(1);
      check("ss_pop_level", fifo_level_out, 0);
      step(1);
      check("ss_pop_empty", fifo_level_out, 0);
      data_ready_in = 1'b0;

      // Trigger while busy is dropped and flagged
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      step(2);
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      check("miss_flag", missed_out, 1);
      check("miss_no_start", start_conversion_out, 0);
      step(1);
      check("miss_no_start2", start_conversion_out, 0);
      single_shot_in = 1'b1;
      clear_flags_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      clear_flags_in = 1'b0;
      check("miss_set_beats_clear", missed_out, 1);
      conversion_finished_in = 1'b1;
      result_in = 16'h1111;
      step(1);
      conversion_finished_in = 1'b0;
      step(1);
      check("miss_level", fifo_level_out, 1);
      check("miss_data", data_out, 16'h1111);
      step(3);
      check("miss_not_queued", busy_out, 0);
      clear_flags_in = 1'b1;
      step(1);
      clear_flags_in = 1'b0;
      check("miss_cleared", missed_out, 0);
      conversion_finished_in = 1'b1;
      step(1);
      conversion_finished_in = 1'b0;
      step(1);
      check("edge_idle_busy", busy_out, 0);
      check("edge_idle_level", fifo_level_out, 1);
      data_ready_in = 1'b1;
      step(1);
      data_ready_in = 1'b0;

      // Overflow with no consumer
      for (int i = 0; i < 4; i++) do_conv(16'(100 + i), 1'b0);
      check("ovf_full_level", fifo_level_out, 4);
      check("ovf_not_yet", overflow_out, 0);
      do_conv(16'd104, 1'b0);
      check("ovf_level", fifo_level_out, 4);
      check("ovf_flag", overflow_out, 1);
      check("ovf_head", data_out, 16'd100);
      clear_flags_in = 1'b1;
      step(1);
      clear_flags_in = 1'b0;
      check("ovf_cleared", overflow_out, 0);

      // Full FIFO, push coinciding with pop
      do_conv(16'd200, 1'b1);
      check("fp_level", fifo_level_out, 4);
      check("fp_no_ovf", overflow_out, 0);
      check("fp_head", data_out, 16'd101);
      data_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fp_drain%0d", i), data_out, exp_q[i]);
         step(1);
      end
      data_ready_in = 1'b0;
      check("fp_empty", data_valid_out, 0);

      // Periodic trigger, 100-cycle period, ADC finishing ~20 cycles after start
      period_in = 16'd100;
      enable_in = 1'b1;
      wait_start("per_start1", t1);
      step(1);
      check("per_w1_hi", start_conversion_out, 1);
      step(1);
      check("per_w1_lo", start_conversion_out, 0);
      step(18);
      conversion_finished_in = 1'b1;
      result_in = 16'h0100;
      step(1);
      conversion_finished_in = 1'b0;
      step(1);
      check("per_level1", fifo_level_out, 1);
      check("per_data1", data_out, 16'h0100);
      wait_start("per_start2", t2);
      check("per_interval", t2 - t1, 100);
      step(1);
      check("per_w2_hi", start_conversion_out, 1);
      step(1);
      check("per_w2_lo", start_conversion_out, 0);
      step(18);
      conversion_finished_in = 1'b1;
      result_in = 16'h0200;
      step(1);
      conversion_finished_in = 1'b0;
      step(1);
      check("per_level2", fifo_level_out, 2);
      check("per_data2", data_out, 16'h0100);
      enable_in = 1'b0;

      // Reset asserted during START
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b1;
      check("rs_start", start_conversion_out, 1);
      step(1);
      single_shot_in = 1'b0;
      check("rs_missed", missed_out, 1);
      rst = 1'b1;
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      check("rs_start_low", start_conversion_out, 0);
      check("rs_busy", busy_out, 0);
      check("rs_level", fifo_level_out, 0);
      check("rs_valid", data_valid_out, 0);
      check("rs_data", data_out, 0);
      check("rs_flags", {missed_out, overflow_out, timeout_out}, 0);
      step(1);
      rst = 1'b0;
      step(1);
      check("rs_idle_after", busy_out, 0);
      do_conv(16'h7777, 1'b0);
      check("rs_conv_level", fifo_level_out, 1);
      check("rs_conv_data", data_out, 16'h7777);
      data_ready_in = 1'b1;
      step(1);
      data_ready_in = 1'b0;
      check("rs_drained", fifo_level_out, 0);

      // ADC never finishes
      single_shot_in = 1'b1;
      step(1);
      single_shot_in = 1'b0;
      step(2);
      check("to_in_wait", busy_out, 1);
      step(63);
      check("to_wait_63", busy_out, 1);
      step(1);
`ifdef ADC_SCHED_TIMEOUT_EN
      check("to_idle", busy_out, 0);
      check("to_flag", timeout_out, 1);
      check("to_level", fifo_level_out, 0);
`else
      check("to_still_busy", busy_out, 1);
      step(200);
      check("to_still_busy_late", busy_out, 1);
      check("to_flag_zero", timeout_out, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
